// File: rtl/pl_int_pkg.sv
// Shared types and constants for the PL interrupt controller: channel FSM states,
// holdoff counter type and route encodings.
package pl_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_HOLDOFF = 2'd2
    } pl_int_state_e;

    typedef logic [11:0] holdoff_cnt_t;

    localparam logic ROUTE_FIQ = 1'b1;
    localparam logic ROUTE_IRQ = 1'b0;

    localparam int CNT_W       = 32;
    localparam int GIC_LINES   = 4;
    localparam int HOLDOFF_MAX = 4095;

endpackage

// File: rtl/pl_int_ctrl_if.sv
// Signal bundle between software/LED counter blocks and the PL interrupt controller.
interface pl_int_ctrl_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0] int_src_i;
    logic [NUM_SRC-1:0] int_en_i;
    logic [NUM_SRC-1:0] fiq_sel_i;
    logic [NUM_SRC-1:0] int_clr_i;
    logic               cnt_clr_i;

    logic [3:0]         fiq_o;
    logic [3:0]         irq_o;
    logic [NUM_SRC-1:0] pend_o;
    logic [NUM_SRC-1:0] miss_o;
    logic [31:0]        int_cnt_fiq_o;
    logic [31:0]        int_cnt_irq_o;

    modport master (
        output int_src_i, int_en_i, fiq_sel_i, int_clr_i, cnt_clr_i,
        input  fiq_o, irq_o, pend_o, miss_o, int_cnt_fiq_o, int_cnt_irq_o
    );

    modport slave (
        input  int_src_i, int_en_i, fiq_sel_i, int_clr_i, cnt_clr_i,
        output fiq_o, irq_o, pend_o, miss_o, int_cnt_fiq_o, int_cnt_irq_o
    );
endinterface

// File: rtl/pl_int_chan.sv
// One interrupt source: rising-edge detect, IDLE/PEND/HOLDOFF sequencing,
// holdoff timer and sticky missed-edge flag.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for an enabled rising edge
//   PEND    | event latched, route held, waiting for software clear
//   HOLDOFF | post-clear mask; down-counter runs HOLDOFF_CYC cycles
module pl_int_chan
    import pl_int_pkg::*;
#(
    parameter int HOLDOFF_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic en,
    input  logic sel,
    input  logic clr,
    output logic pend,
    output logic route,
    output logic miss,
    output logic enter
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] PEND    = ST_PEND;
    localparam logic [1:0] HOLDOFF = ST_HOLDOFF;

    localparam holdoff_cnt_t HOLD_LOAD = holdoff_cnt_t'(HOLDOFF_CYC - 1);

    if (HOLDOFF_CYC < 1 || HOLDOFF_CYC > HOLDOFF_MAX) begin : g_bad_holdoff
        $error("pl_int_chan: HOLDOFF_CYC out of range 1..4095");
    end

    logic [1:0]   state;
    logic         src_q;
    logic         primed;
    logic         rise;
    holdoff_cnt_t hold_cnt;

    // primed stays low for the first cycle after reset so a level already high
    // at release is absorbed into src_q instead of being seen as an edge.
    assign rise  = src & ~src_q & primed;
    assign enter = (state == IDLE) & rise & en;
    assign pend  = (state == PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_q    <= 1'b0;
            primed   <= 1'b0;
            hold_cnt <= '0;
            route    <= ROUTE_IRQ;
            miss     <= 1'b0;
        end else begin
            src_q  <= src;
            primed <= 1'b1;

            case (state)
                IDLE: begin
                    if (rise && en) begin
                        state <= PEND;
                        route <= sel;
                    end
                end
                PEND: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (clr) begin
                        state    <= HOLDOFF;
                        hold_cnt <= HOLD_LOAD;
                        miss     <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new edge while busy outranks a same-cycle clear of the flag.
            if ((state == PEND || state == HOLDOFF) && rise) begin
                miss <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pl_int_ctrl.sv
// PL interrupt controller: NUM_SRC edge-triggered channels merged onto one FIQ
// and one IRQ line towards the APU GIC, with per-route delivery counters.
module pl_int_ctrl
    import pl_int_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic         clk100,
    input  logic         rst,
    pl_int_ctrl_if.slave bus
);

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] route;
    logic [NUM_SRC-1:0] miss;
    logic [NUM_SRC-1:0] enter;
    logic [NUM_SRC-1:0] fiq_mask;
    logic [NUM_SRC-1:0] irq_mask;

    logic [CNT_W-1:0]   inc_fiq;
    logic [CNT_W-1:0]   inc_irq;
    logic [CNT_W-1:0]   cnt_fiq;
    logic [CNT_W-1:0]   cnt_irq;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_chan
        pl_int_chan #(
            .HOLDOFF_CYC (HOLDOFF_CYC)
        ) u_chan (
            .clk   (clk100),
            .rst   (rst),
            .src   (bus.int_src_i[n]),
            .en    (bus.int_en_i[n]),
            .sel   (bus.fiq_sel_i[n]),
            .clr   (bus.int_clr_i[n]),
            .pend  (pend[n]),
            .route (route[n]),
            .miss  (miss[n]),
            .enter (enter[n])
        );

        assign fiq_mask[n] = pend[n] & (route[n] == ROUTE_FIQ);
        assign irq_mask[n] = pend[n] & (route[n] == ROUTE_IRQ);
    end

    // A channel entering PEND takes its route from fiq_sel this cycle,
    // which is the same value it latches.
    always_comb begin
        inc_fiq = '0;
        inc_irq = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (enter[n]) begin
                if (bus.fiq_sel_i[n] == ROUTE_FIQ) begin
                    inc_fiq = inc_fiq + 32'd1;
                end else begin
                    inc_irq = inc_irq + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst || bus.cnt_clr_i) begin
            cnt_fiq <= '0;
            cnt_irq <= '0;
        end else begin
            cnt_fiq <= cnt_fiq + inc_fiq;
            cnt_irq <= cnt_irq + inc_irq;
        end
    end

    assign bus.pend_o        = pend;
    assign bus.miss_o        = miss;
    assign bus.fiq_o         = {3'b000, |fiq_mask};
    assign bus.irq_o         = {3'b000, |irq_mask};
    assign bus.int_cnt_fiq_o = cnt_fiq;
    assign bus.int_cnt_irq_o = cnt_irq;

endmodule

// File: tb/tb_pl_int_ctrl.sv
// Self-checking bench for pl_int_ctrl: fixed vector table, directed corner-case
// sequences and randomized traffic against an event-level reference model.
module tb_pl_int_ctrl;

    localparam int NS = 3;
    localparam int H  = 16;

    logic clk100 = 1'b0;
    logic rst;
    always #5 clk100 = ~clk100;

    pl_int_ctrl_if #(.NUM_SRC(NS)) bus();

    pl_int_ctrl #(
        .NUM_SRC     (NS),
        .HOLDOFF_CYC (H)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per source a pending bit, a count of holdoff cycles left,
    // the route chosen for the current event, the miss flag and last input level.
    logic [NS-1:0] m_pend, m_route, m_miss, m_prev;
    int            m_hold [NS];
    bit            m_primed;
    logic [31:0]   m_cf, m_ci;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_route = '0; m_miss = '0; m_prev = '0;
        m_primed = 1'b0; m_cf = '0; m_ci = '0;
        for (int n = 0; n < NS; n++) m_hold[n] = 0;
    endtask

    task automatic model_step();
        int nf;
        int ni;
        bit rise;
        nf = 0;
        ni = 0;
        if (rst) begin
            model_reset();
        end else begin
            for (int n = 0; n < NS; n++) begin
                rise = bus.int_src_i[n] && !m_prev[n] && m_primed;
                if (m_pend[n]) begin
                    if (!bus.int_en_i[n]) begin
                        m_pend[n] = 1'b0;
                    end else if (bus.int_clr_i[n]) begin
                        m_pend[n] = 1'b0;
                        m_hold[n] = H;
                        m_miss[n] = 1'b0;
                    end
                    if (rise) m_miss[n] = 1'b1;
                end else if (m_hold[n] > 0) begin
                    m_hold[n]--;
                    if (rise) m_miss[n] = 1'b1;
                end else if (rise && bus.int_en_i[n]) begin
                    m_pend[n]  = 1'b1;
                    m_route[n] = bus.fiq_sel_i[n];
                    if (bus.fiq_sel_i[n]) nf++; else ni++;
                end
                m_prev[n] = bus.int_src_i[n];
            end
            m_primed = 1'b1;
            if (bus.cnt_clr_i) begin
                m_cf = '0;
                m_ci = '0;
            end else begin
                m_cf = m_cf + 32'(nf);
                m_ci = m_ci + 32'(ni);
            end
        end
    endtask

    task automatic check_model();
        check("mdl_pend", 32'(bus.pend_o), 32'(m_pend));
        check("mdl_miss", 32'(bus.miss_o), 32'(m_miss));
        check("mdl_fiq",  32'(bus.fiq_o),  {31'b0, |(m_pend & m_route)});
        check("mdl_irq",  32'(bus.irq_o),  {31'b0, |(m_pend & ~m_route)});
        check("mdl_cfiq", bus.int_cnt_fiq_o, m_cf);
        check("mdl_cirq", bus.int_cnt_irq_o, m_ci);
    endtask

    task automatic tick();
        @(posedge clk100);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drive(input logic [NS-1:0] src, input logic [NS-1:0] en,
                         input logic [NS-1:0] sel, input logic [NS-1:0] clr, input logic cc);
        bus.int_src_i = src;
        bus.int_en_i  = en;
        bus.fiq_sel_i = sel;
        bus.int_clr_i = clr;
        bus.cnt_clr_i = cc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          r;
        logic [NS-1:0] src, en, sel, clr;
        logic          cc;
        logic [NS-1:0] pend, miss;
        logic          fiq, irq;
        logic [31:0]   cf, ci;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1'b1;
        drive('0, '0, '0, '0, 1'b0);
        model_reset();

        //         r     src     en      sel     clr     cc    pend    miss    fiq   irq   cf  ci
        tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 3'b000, 3'b111, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 3'b001, 3'b111, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{1'b0, 3'b001, 3'b111, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{1'b0, 3'b111, 3'b111, 3'b001, 3'b000, 1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 1, 2};
        tbl[5] = '{1'b0, 3'b111, 3'b111, 3'b110, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1, 2};
        tbl[6] = '{1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1, 2};
        tbl[7] = '{1'b0, 3'b010, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1, 2};
        tbl[8] = '{1'b0, 3'b010, 3'b111, 3'b000, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 0, 0};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].r;
            drive(tbl[i].src, tbl[i].en, tbl[i].sel, tbl[i].clr, tbl[i].cc);
            tick();
            check($sformatf("tbl%0d_pend", i), 32'(bus.pend_o), 32'(tbl[i].pend));
            check($sformatf("tbl%0d_miss", i), 32'(bus.miss_o), 32'(tbl[i].miss));
            check($sformatf("tbl%0d_fiq", i),  32'(bus.fiq_o),  {31'b0, tbl[i].fiq});
            check($sformatf("tbl%0d_irq", i),  32'(bus.irq_o),  {31'b0, tbl[i].irq});
            check($sformatf("tbl%0d_cf", i),   bus.int_cnt_fiq_o, tbl[i].cf);
            check($sformatf("tbl%0d_ci", i),   bus.int_cnt_irq_o, tbl[i].ci);
        end

        // Holdoff boundaries: an edge on the last holdoff cycle is a miss,
        // an edge on the first cycle after it is accepted.
        do_reset();
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        check("ho_pend_on", 32'(bus.fiq_o), 32'd1);
        drive(3'b000, 3'b001, 3'b001, 3'b001, 1'b0); tick();
        check("ho_fiq_off", 32'(bus.fiq_o), 32'd0);
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0);
        for (int d = 1; d < H; d++) tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        check("ho_last_miss", 32'(bus.miss_o), 32'd1);
        check("ho_last_nopend", 32'(bus.pend_o), 32'd0);
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        check("ho_idle_accept", 32'(bus.pend_o), 32'd1);
        drive(3'b001, 3'b001, 3'b001, 3'b001, 1'b0); tick();
        check("ho_miss_cleared", 32'(bus.miss_o), 32'd0);
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0);
        for (int d = 1; d <= H; d++) tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        check("ho_after_accept", 32'(bus.pend_o), 32'd1);
        check("ho_after_nomiss", 32'(bus.miss_o), 32'd0);

        // Simultaneous edges on both routes, then enable drop racing a clear.
        do_reset();
        drive(3'b000, 3'b111, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b111, 3'b111, 3'b001, 3'b000, 1'b0); tick();
        check("sim_cfiq", bus.int_cnt_fiq_o, 32'd1);
        check("sim_cirq", bus.int_cnt_irq_o, 32'd2);
        drive(3'b111, 3'b101, 3'b001, 3'b010, 1'b0); tick();
        check("endrop_pend", 32'(bus.pend_o), 32'b101);
        drive(3'b101, 3'b111, 3'b111, 3'b000, 1'b0); tick();
        drive(3'b111, 3'b111, 3'b111, 3'b000, 1'b0); tick();
        check("endrop_reaccept", 32'(bus.pend_o), 32'b111);
        check("endrop_cfiq", bus.int_cnt_fiq_o, 32'd2);

        // Counter wrap from a forced all-ones value, then clear beating an event.
        do_reset();
        drive(3'b000, 3'b111, 3'b000, 3'b000, 1'b0); tick();
        force dut.cnt_irq = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_irq;
        m_ci = 32'hFFFF_FFFF;
        drive(3'b001, 3'b111, 3'b000, 3'b000, 1'b0); tick();
        check("wrap_cirq", bus.int_cnt_irq_o, 32'd0);
        drive(3'b011, 3'b111, 3'b000, 3'b000, 1'b1); tick();
        check("cclr_prio", bus.int_cnt_irq_o, 32'd0);
        check("cclr_pend", 32'(bus.pend_o), 32'b011);

        // Reset in holdoff with the source held high.
        do_reset();
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b001, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick(); tick();
        rst = 1'b1; tick();
        check("rst_fiq",  32'(bus.fiq_o),  32'd0);
        check("rst_cfiq", bus.int_cnt_fiq_o, 32'd0);
        check("rst_pend", 32'(bus.pend_o), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < H + 4; i++) tick();
        check("rst_high_noedge", 32'(bus.pend_o), 32'd0);
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        drive(3'b001, 3'b001, 3'b001, 3'b000, 1'b0); tick();
        check("rst_fresh_edge", 32'(bus.pend_o), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        begin
            logic [NS-1:0] src;
            logic [NS-1:0] en;
            src = '0;
            en  = 3'b111;
            for (int c = 0; c < 3000; c++) begin
                for (int n = 0; n < NS; n++) begin
                    if ($urandom_range(0, 2) == 0) src[n] = ~src[n];
                    if ($urandom_range(0, 19) == 0) en[n] = ~en[n];
                end
                rst = ($urandom_range(0, 299) == 0);
                drive(src, en, NS'($urandom),
                      NS'($urandom) & NS'($urandom) & NS'($urandom),
                      $urandom_range(0, 39) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pl_int_ctrl.md
PL_INT_CTRL -- requirements
Module: pl_int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 3: number of PL interrupt sources.
REQ-002 Parameter HOLDOFF_CYC, default 16: idle cycles a source is masked after its clear (1..4095).
REQ-003 clk100  input  1  the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 int_src_i  input  NUM_SRC  interrupt request levels from the LED counter blocks, bit n = source n.
REQ-006 int_en_i  input  NUM_SRC  per-source enable.
REQ-007 fiq_sel_i  input  NUM_SRC  per-source route: 1 = FIQ, 0 = IRQ.
REQ-008 int_clr_i  input  NUM_SRC  per-source single-cycle clear (acknowledge) pulse from software.
REQ-009 cnt_clr_i  input  1  single-cycle pulse zeroing both delivery counters.
REQ-010 fiq_o  output  4  active-high to pl_ps_apugic_fiq; bit 0 used, bits 3:1 tied 0.
REQ-011 irq_o  output  4  active-high to pl_ps_apugic_irq; bit 0 used, bits 3:1 tied 0.
REQ-012 pend_o  output  NUM_SRC  per-source pending status.
REQ-013 miss_o  output  NUM_SRC  sticky per-source missed-edge flag.
REQ-014 int_cnt_fiq_o  output  32  FIQ deliveries; int_cnt_irq_o  output  32  IRQ deliveries.

Function
REQ-015 Each source SHALL register int_src_i[n] once; a rising edge is int_src_i[n] & ~registered value.
REQ-016 Each source SHALL run an FSM with states IDLE, PEND, HOLDOFF.
REQ-017 IDLE -> PEND on a rising edge with int_en_i[n]=1; edges while disabled are discarded, not flagged.
REQ-018 On PEND entry, fiq_sel_i[n] SHALL be latched as the route; later fiq_sel_i changes do not affect that event.
REQ-019 pend_o[n] SHALL be 1 exactly while in PEND, visible the cycle after the edge on which the rising edge is sampled (latency 1).
REQ-020 PEND -> HOLDOFF on int_clr_i[n]=1; HOLDOFF loads a counter with HOLDOFF_CYC-1 and returns to IDLE after exactly HOLDOFF_CYC cycles.
REQ-021 PEND -> IDLE, no HOLDOFF, when int_en_i[n] falls; int_clr_i[n] in the same cycle is ignored.
REQ-022 A rising edge in PEND or HOLDOFF SHALL set miss_o[n]; miss_o[n] clears only on int_clr_i[n] asserted while in PEND.
REQ-023 int_clr_i[n] in IDLE or HOLDOFF SHALL have no effect.
REQ-024 fiq_o[0] = OR of pend_o over sources with latched route FIQ; irq_o[0] likewise for IRQ; both are registered-state derived, glitch-free.
REQ-025 int_cnt_fiq_o / int_cnt_irq_o SHALL increment by the number of sources entering PEND on that route in the cycle (0..NUM_SRC) and wrap modulo 2^32.
REQ-026 cnt_clr_i SHALL zero both counters and takes priority over a same-cycle increment.

Reset
REQ-027 rst SHALL put every FSM in IDLE and zero holdoff counters, edge registers, pend_o, miss_o, fiq_o, irq_o and both counters on the next clock edge.
REQ-028 rst mid-PEND or mid-HOLDOFF SHALL abandon the event without counting; an int_src_i already high at reset release is not an edge.

Structure
REQ-029 Package pl_int_pkg SHALL hold the FSM state enum (IDLE, PEND, HOLDOFF), the 12-bit holdoff counter type and the FIQ/IRQ route constants.
REQ-030 One sub-module pl_int_chan SHALL implement a single source (edge detect, FSM, holdoff, miss flag), instantiated NUM_SRC times; routing OR and counters stay in pl_int_ctrl.

Verification
REQ-031 Src0 enabled, fiq_sel=1, rising edge at cycle 10 -> fiq_o[0]=1, pend_o=3'b001 from cycle 11; int_cnt_fiq_o=1; irq_o=0.
REQ-032 Clear src0 at cycle 20, HOLDOFF_CYC=16 -> fiq_o[0]=0 from cycle 21; edge at cycle 30 sets miss_o[0], no new PEND; edge at cycle 40 -> PEND at cycle 41.
REQ-033 Src0 (FIQ) and src1 (IRQ) edges same cycle, src2 (IRQ) edge same cycle -> both counters move: fiq +1, irq +2.
REQ-034 Src1 pending, int_en_i[1] dropped together with int_clr_i[1] -> IDLE next cycle, no holdoff; new edge two cycles later accepted.
REQ-035 Preload int_cnt_irq_o to 32'hFFFF_FFFF via 2^32-1 events (or forced) plus one IRQ event -> 0; cnt_clr_i coincident with an event -> 0.
REQ-036 rst asserted mid-HOLDOFF with int_src_i held high -> all outputs 0 next cycle; no PEND after release until int_src_i falls and rises.
